// File: rtl/imem_arbiter.sv
// Arbitrates a CPU fetch port and a program-loader write port onto one
// single-port instruction memory. Define IMEM_ARB_RR_EN for round-robin contention.
module imem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_data,
  input  logic        load_req,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_wdata,
  input  logic        load_last,
  output logic        load_gnt,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        busy,
  output logic [7:0]  load_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2} state_t;

  state_t state, state_nxt;

`ifdef IMEM_ARB_RR_EN
  // High when the loader wins the next contended cycle.
  logic prio_load;

  always_ff @(posedge clk or negedge rst)
    if (!rst)          prio_load <= 1'b1;
    else if (load_gnt) prio_load <= 1'b0;
    else if (fetch_gnt) prio_load <= 1'b1;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // Grants: gated by reset so nothing reaches memory while held in reset.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (rst) begin
      if (state == LOAD) begin
        load_gnt = load_req;
      end else if (fetch_req && load_req) begin
`ifdef IMEM_ARB_RR_EN
        load_gnt  = prio_load;
        fetch_gnt = !prio_load;
`else
        load_gnt  = 1'b1;
`endif
      end else begin
        load_gnt  = load_req;
        fetch_gnt = fetch_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (load_gnt && load_last) state_nxt = IDLE;
      default: begin
        if (load_gnt)       state_nxt = load_last ? IDLE : LOAD;
        else if (fetch_gnt) state_nxt = FETCH;
        else                state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_wren    = load_gnt;
    mem_address = load_gnt ? load_addr : (fetch_gnt ? fetch_addr : 8'd0);
    mem_data    = load_gnt ? load_wdata : 32'd0;
    busy        = (state == LOAD);
    fetch_data  = mem_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) fetch_rvalid <= 1'b0;
    else      fetch_rvalid <= fetch_gnt;

  // A grant outside LOAD is the first beat of a new burst.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      load_count <= 8'd0;
    end else if (load_gnt) begin
      if (state != LOAD)              load_count <= 8'd1;
      else if (load_count != 8'hFF)   load_count <= load_count + 8'd1;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a transaction-level model predicts each
// cycle's grants and memory traffic; a negedge monitor pops and compares.
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0, load_req = 1'b0, load_last = 1'b0;
  logic [7:0]  fetch_addr = 8'd0, load_addr = 8'd0;
  logic [31:0] load_wdata = 32'd0;
  logic        fetch_gnt, fetch_rvalid, load_gnt, mem_wren, busy;
  logic [31:0] fetch_data, mem_data;
  logic [31:0] mem_q;
  logic [7:0]  mem_address, load_count;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_data(fetch_data),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
    .load_last(load_last), .load_gnt(load_gnt),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .load_count(load_count)
  );

  // Single-port synchronous memory, one cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  typedef struct packed {
    logic        fg, lg, busy, wren;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] dq[$];
  int          total = 0;
  int          bad = 0;

  // Reference model: burst ownership, who won last, beat count, memory image.
  bit          m_load;
  bit          m_last_load;
  int          m_cnt;
  logic [31:0] ref_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 ^ (i * 32'h00010101);
  endfunction

  task automatic model_reset();
    m_load = 0; m_last_load = 0; m_cnt = 0;
  endtask

  // Drive one cycle of requests, predict the DUT response, advance to posedge+1.
  task automatic cyc(input bit fr, input logic [7:0] fa, input bit lr,
                     input logic [7:0] la, input logic [31:0] ld, input bit ll);
    exp_t e;
    bit fg, lg;
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la;
    load_wdata = ld; load_last = ll;
    fg = 0; lg = 0;
    if (m_load) lg = lr;
    else if (fr && lr) begin
`ifdef IMEM_ARB_RR_EN
      lg = !m_last_load; fg = m_last_load;
`else
      lg = 1;
`endif
    end else begin
      fg = fr; lg = lr;
    end
    e.fg = fg; e.lg = lg; e.busy = m_load; e.wren = lg;
    e.addr = lg ? la : (fg ? fa : 8'd0);
    e.data = lg ? ld : 32'd0;
    e.cnt  = 8'(m_cnt);
    expq.push_back(e);
    if (fg) begin
      dq.push_back(ref_mem[fa]);
      m_last_load = 0;
    end
    if (lg) begin
      ref_mem[la] = ld;
      m_cnt = !m_load ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
      m_load = !ll;
      m_last_load = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'd0, 0, 8'd0, 32'd0, 0);
  endtask

  // Monitor: compares every cycle the driver scheduled.
  bit prev_fg = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_fg = 0;
    end else begin
      if (fetch_rvalid) begin
        if (dq.size() == 0) chk("rvalid_unexpected", 32'(fetch_rvalid), 32'd0);
        else                chk("fetch_data", fetch_data, dq.pop_front());
      end
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("fetch_gnt",   32'(fetch_gnt),  32'(e.fg));
        chk("load_gnt",    32'(load_gnt),   32'(e.lg));
        chk("mem_wren",    32'(mem_wren),   32'(e.wren));
        chk("mem_address", 32'(mem_address), 32'(e.addr));
        chk("mem_data",    mem_data,         e.data);
        chk("busy",        32'(busy),        32'(e.busy));
        chk("load_count",  32'(load_count),  32'(e.cnt));
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(prev_fg));
        prev_fg = e.fg;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_wren"},   32'(mem_wren),     32'd0);
    chk({tag, "_lgnt"},   32'(load_gnt),     32'd0);
    chk({tag, "_fgnt"},   32'(fetch_gnt),    32'd0);
    chk({tag, "_busy"},   32'(busy),         32'd0);
    chk({tag, "_cnt"},    32'(load_count),   32'd0);
    chk({tag, "_rvalid"}, 32'(fetch_rvalid), 32'd0);
  endtask

  // Assert reset mid-cycle with requests still active.
  task automatic pulse_reset();
    rst = 0;
    #1;
    reset_checks("rst_async");
    dq.delete();
    model_reset();
    @(posedge clk); #1;
    reset_checks("rst_held");
    fetch_req = 0; load_req = 0;
    rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1;

    // Back-to-back fetches of words 0..3 starting the first cycle out of reset.
    for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, 8'd0, 32'd0, 0);
    idle(2);

    // Four-beat loader burst with fetch_req held high throughout.
    for (int i = 0; i < 4; i++)
      cyc(1, 8'h40, 1, 8'(8'h10 + i), 32'(32'hA0 + i), i == 3);
    idle(1);
    chk("burst_count", 32'(load_count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h10 + i), 0, 8'd0, 32'd0, 0);
    idle(2);

    // Contention with single-beat loads, from a fresh reset pointer.
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 1, 8'(8'h30 + i), 32'(32'hB0 + i), 1);
    idle(2);

    // Burst with request gaps: ownership held, fetch locked out.
    cyc(1, 8'h05, 1, 8'h50, 32'hCAFE0001, 0);
    cyc(1, 8'h05, 0, 8'h00, 32'd0, 0);
    cyc(1, 8'h05, 0, 8'h00, 32'd0, 0);
    cyc(1, 8'h05, 1, 8'h51, 32'hCAFE0002, 1);
    cyc(1, 8'h50, 0, 8'h00, 32'd0, 0);
    cyc(1, 8'h51, 0, 8'h00, 32'd0, 0);
    idle(1);

    // Long burst to reach count saturation.
    for (int i = 0; i < 260; i++)
      cyc(0, 8'd0, 1, 8'(8'h80 + (i % 16)), 32'(i), i == 259);
    idle(1);
    chk("count_saturate", 32'(load_count), 32'd255);

    // Reset mid-burst after two beats, then a fetch right after release.
    cyc(0, 8'd0, 1, 8'h60, 32'hD0, 0);
    cyc(0, 8'd0, 1, 8'h61, 32'hD1, 0);
    load_req = 1; load_addr = 8'h62; load_wdata = 32'hD2;
    pulse_reset();
    cyc(1, 8'h62, 0, 8'd0, 32'd0, 0);
    cyc(1, 8'h61, 0, 8'd0, 32'd0, 0);
    idle(2);

    // Randomized traffic over a small address window to hit read-after-write.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, 8'($urandom_range(0, 31)),
          $urandom_range(0, 2) == 0, 8'($urandom_range(0, 31)),
          $urandom, $urandom_range(0, 2) == 0);
    // Close any open burst, then drain.
    cyc(0, 8'd0, 1, 8'h1F, 32'hFEED, 1);
    idle(3);
    chk("drain_data_q", 32'(dq.size()), 32'd0);
    chk("drain_exp_q",  32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
